// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with two combinational read ports,
// one synchronous write port, optional hardwired-zero r0, optional
// write-to-read bypass and a per-register busy scoreboard for hazard checks.
module regfile_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      rd_addr1,
    input  logic [ADDR_W-1:0]      rd_addr2,
    output logic [DATA_W-1:0]      rd_data1,
    output logic [DATA_W-1:0]      rd_data2,
    output logic                   busy1,
    output logic                   busy2,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   issue_en,
    input  logic [ADDR_W-1:0]      issue_addr,
    output logic [(2**ADDR_W)-1:0] busy_vec
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam logic        HAS_ZERO = (ZERO_REG != 0);
    localparam logic        HAS_BYP  = (BYPASS != 0);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                wr_keep;

    logic [ADDR_W-1:0]   port_addr [2];
    logic [DATA_W-1:0]   port_data [2];
    logic                port_busy [2];

    // Writes to a hardwired r0 are dropped.
    assign wr_keep = wr_en && !(HAS_ZERO && (wr_addr == '0));

    // Scoreboard update: retiring write clears, a new issue wins over it.
    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (issue_en) begin
            busy_next[issue_addr] = 1'b1;
        end
        if (HAS_ZERO) begin
            busy_next[0] = 1'b0;
        end
    end

    // Register storage and busy bits; reset overrides write and issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_keep) begin
                regs[wr_addr] <= wr_data;
            end
            busy <= busy_next;
        end
    end

    assign port_addr[0] = rd_addr1;
    assign port_addr[1] = rd_addr2;

    // Read muxes: zero register first, then bypass, then stored state.
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            port_data[p] = regs[port_addr[p]];
            port_busy[p] = busy[port_addr[p]];
            if (HAS_ZERO && (port_addr[p] == '0)) begin
                port_data[p] = '0;
                port_busy[p] = 1'b0;
            end else if (HAS_BYP && wr_en && (wr_addr == port_addr[p])) begin
                port_data[p] = wr_data;
                port_busy[p] = 1'b0;
            end
        end
    end

    assign rd_data1 = port_data[0];
    assign rd_data2 = port_data[1];
    assign busy1    = port_busy[0];
    assign busy2    = port_busy[1];
    assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of regfile_sb in its default configuration
// (zero register, bypass) and in a plain configuration (no zero, no bypass),
// both driven from the same stimulus.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rd_addr1, rd_addr2, wr_addr, issue_addr;
    logic [15:0] wr_data;
    logic        wr_en, issue_en;

    logic [15:0] d_rd1, d_rd2, a_rd1, a_rd2;
    logic        d_b1, d_b2, a_b1, a_b2;
    logic [15:0] d_vec, a_vec;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    regfile_sb u_dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(d_rd1), .rd_data2(d_rd2),
        .busy1(d_b1), .busy2(d_b2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .busy_vec(d_vec)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) u_alt (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(a_rd1), .rd_data2(a_rd2),
        .busy1(a_b1), .busy2(a_b2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .busy_vec(a_vec)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Move to the next falling edge, clear strobes, then settle.
    task automatic next_cycle();
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0; issue_en = 1'b0;
    endtask

    initial begin
        rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; issue_addr = '0; wr_data = '0;
        // Reset with a competing write and issue
        @(negedge clk);
        rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hFFFF;
        issue_en = 1'b1; issue_addr = 4'd3;
        next_cycle();
        rd_addr1 = 4'd3; rd_addr2 = 4'd3; #1;
        check("rst_rd1", d_rd1, 16'h0000);
        check("rst_busy1", d_b1, 1'b0);
        check("rst_vec", d_vec, 16'h0000);
        check("alt_rst_rd1", a_rd1, 16'h0000);
        check("alt_rst_vec", a_vec, 16'h0000);

        // Write r5 and r0, with r0 read during its own write
        next_cycle();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
        next_cycle();
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234; rd_addr2 = 4'd0; #1;
        check("r0_wr_cycle", d_rd2, 16'h0000);
        next_cycle();
        rd_addr1 = 4'd5; rd_addr2 = 4'd0; #1;
        check("r5_rd", d_rd1, 16'hBEEF);
        check("r0_zero", d_rd2, 16'h0000);
        check("alt_r5_rd", a_rd1, 16'hBEEF);
        check("alt_r0_rd", a_rd2, 16'h1234);
        check("nowr_issue_vec", d_vec, 16'h0000);

        // Bypass
        next_cycle();
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0001;
        next_cycle();
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hA5A5;
        rd_addr1 = 4'd7; rd_addr2 = 4'd7; #1;
        check("byp_rd1", d_rd1, 16'hA5A5);
        check("byp_rd2", d_rd2, 16'hA5A5);
        check("alt_nobyp_rd1", a_rd1, 16'h0001);
        check("alt_nobyp_rd2", a_rd2, 16'h0001);
        next_cycle(); #1;
        check("alt_after_rd1", a_rd1, 16'hA5A5);
        check("after_rd1", d_rd1, 16'hA5A5);

        // Scoreboard lifecycle on r9
        next_cycle();
        issue_en = 1'b1; issue_addr = 4'd9; rd_addr1 = 4'd9; #1;
        check("issue_not_comb", d_b1, 1'b0);
        next_cycle(); #1;
        check("sb_busy1_c1", d_b1, 1'b1);
        check("sb_vec_c1", d_vec, 16'h0200);
        check("alt_busy1_c1", a_b1, 1'b1);
        next_cycle(); #1;
        check("sb_busy1_c2", d_b1, 1'b1);
        next_cycle();
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h0042; #1;
        check("sb_busy1_c3", d_b1, 1'b0);
        check("sb_rd1_c3", d_rd1, 16'h0042);
        check("sb_vec_c3", d_vec, 16'h0200);
        check("alt_busy1_c3", a_b1, 1'b1);
        check("alt_rd1_c3", a_rd1, 16'h0000);
        next_cycle(); #1;
        check("sb_vec_c4", d_vec, 16'h0000);
        check("alt_busy1_c4", a_b1, 1'b0);
        check("alt_rd1_c4", a_rd1, 16'h0042);

        // Simultaneous issue and write to busy r4
        next_cycle();
        issue_en = 1'b1; issue_addr = 4'd4; rd_addr1 = 4'd4;
        next_cycle();
        issue_en = 1'b1; issue_addr = 4'd4;
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h4444; #1;
        check("sim_busy1_byp", d_b1, 1'b0);
        check("sim_rd1_byp", d_rd1, 16'h4444);
        check("alt_sim_busy1", a_b1, 1'b1);
        next_cycle(); #1;
        check("sim_vec", d_vec, 16'h0010);
        check("alt_sim_vec", a_vec, 16'h0010);
        check("sim_busy1", d_b1, 1'b1);
        next_cycle();
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h5555;
        next_cycle(); #1;
        check("sim_clear_vec", d_vec, 16'h0000);
        check("sim_clear_rd1", d_rd1, 16'h5555);

        // Issue to r0
        next_cycle();
        issue_en = 1'b1; issue_addr = 4'd0; rd_addr2 = 4'd0;
        next_cycle(); #1;
        check("r0_issue_vec", d_vec, 16'h0000);
        check("r0_issue_busy2", d_b2, 1'b0);
        check("alt_r0_issue_vec", a_vec, 16'h0001);
        check("alt_r0_issue_busy2", a_b2, 1'b1);

        // Reset with r2 and r6 busy, then a late writeback
        issue_en = 1'b1; issue_addr = 4'd2;
        next_cycle();
        issue_en = 1'b1; issue_addr = 4'd6;
        next_cycle(); #1;
        check("pre_rst_vec", d_vec, 16'h0044);
        check("alt_pre_rst_vec", a_vec, 16'h0045);
        rst = 1'b1; issue_en = 1'b1; issue_addr = 4'd5;
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h7777;
        next_cycle();
        rd_addr1 = 4'd5; rd_addr2 = 4'd6; #1;
        check("mid_rst_vec", d_vec, 16'h0000);
        check("alt_mid_rst_vec", a_vec, 16'h0000);
        check("mid_rst_rd1", d_rd1, 16'h0000);
        check("mid_rst_busy2", d_b2, 1'b0);
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h2222;
        next_cycle();
        rd_addr1 = 4'd2; #1;
        check("late_wb_rd1", d_rd1, 16'h2222);
        check("late_wb_vec", d_vec, 16'h0000);
        check("alt_late_wb_rd1", a_rd1, 16'h2222);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
